aes_core_arbiter: RTL and testbench

//  Shares one AESTOP encrypt/decrypt core between NUM_REQ requesters. Each requester gets a

---
 rtl/aes_core_arbiter_pkg.sv | 16 +
 rtl/aes_core_arbiter_if.sv | 30 +++
 rtl/aes_core_arbiter_rr.sv | 38 +++
 rtl/aes_core_arbiter.sv | 136 +++++++++++++
 tb/tb_aes_core_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_core_arbiter_pkg.sv
// Shared constants and FSM state type for the AES core arbiter.
package aes_ctrl_pkg;

   localparam int   AES_BLK_W = 128;
   localparam logic MODE_ENC  = 1'b0;
   localparam logic MODE_DEC  = 1'b1;

   // IDLE -> START -> WAIT -> RESP -> IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Host-side request/response channels for all requesters, packed per requester.
interface aes_core_arbiter_if
#(
   parameter int NUM_REQ = 2
);
   import aes_ctrl_pkg::*;

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           req_mode;
   logic [NUM_REQ*AES_BLK_W-1:0] req_key;
   logic [NUM_REQ*AES_BLK_W-1:0] req_data;
   logic [NUM_REQ-1:0]           resp_valid;
   logic [NUM_REQ-1:0]           resp_ready;
   logic [AES_BLK_W-1:0]         resp_data;
   logic                         resp_err;

   // Host channel logic drives requests and consumes responses.
   modport master (
      output req_valid, req_mode, req_key, req_data, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   // The arbiter accepts requests and produces responses.
   modport slave (
      input  req_valid, req_mode, req_key, req_data, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );

endinterface

// File: rtl/aes_core_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above i_ptr, with wrap.
module rr_arbiter
#(
   parameter int NUM_REQ = 2,
   parameter int IDW     = 1
)
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [IDW-1:0]     o_gnt,
   output logic               o_found
);

   logic [IDW-1:0]     w_idx [NUM_REQ];
   logic [NUM_REQ-1:0] w_hit;

   // w_idx[k] is the requester k places after the pointer; w_hit[k] is its request
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign w_idx[gi] = IDW'((int'(i_ptr) + gi) % NUM_REQ);
         assign w_hit[gi] = i_req[w_idx[gi]];
      end
   endgenerate

   // Smallest rotation offset with a pending request wins
   always_comb begin
      o_gnt   = '0;
      o_found = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            o_gnt   = w_idx[k];
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between NUM_REQ requesters: round-robin grant, one block in
// flight, watchdog abort when the core never signals ready.
module aes_core_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int TIMEOUT_CYC = 64
)
(
   input  logic                 clk,
   input  logic                 rst,
   aes_core_arbiter_if.slave    host,
   output logic                 core_start,
   output logic                 core_mode,
   output logic [AES_BLK_W-1:0] core_key,
   output logic [AES_BLK_W-1:0] core_in,
   input  logic [AES_BLK_W-1:0] core_cipher,
   input  logic                 core_ready,
   output logic                 busy
);

   localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [IDW-1:0]       r_rr_ptr;
   logic [IDW-1:0]       r_gnt_idx;
   logic                 r_mode;
   logic [AES_BLK_W-1:0] r_key;
   logic [AES_BLK_W-1:0] r_data;
   logic [AES_BLK_W-1:0] r_result;
   logic                 r_err;
   logic [CW-1:0]        r_wdog;
   logic [IDW-1:0]       w_gnt;
   logic                 w_found;
   logic                 w_accept;
   logic                 w_timeout;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr (
      .i_req   (host.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_gnt),
      .o_found (w_found)
   );

   // No grant is offered while reset is held so every output reads zero in reset
   assign w_accept  = (r_state == ST_IDLE) && w_found && !rst;
   // Ready beats the watchdog when both land in the same cycle
   assign w_timeout = (r_state == ST_WAIT) && !core_ready && (r_wdog == LAST_CNT);

   assign core_mode      = r_mode;
   assign core_key       = r_key;
   assign core_in        = r_data;
   assign host.resp_data = r_result;
   assign host.resp_err  = r_err;
   assign busy           = (r_state != ST_IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and the per-state handshake strobes
   always_comb begin
      w_state_next    = r_state;
      host.req_ready  = '0;
      host.resp_valid = '0;
      core_start      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               host.req_ready[w_gnt] = 1'b1;
               w_state_next          = ST_START;
            end
         end
         ST_START: begin
            core_start   = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_ready || w_timeout) w_state_next = ST_RESP;
         end
         ST_RESP: begin
            host.resp_valid[r_gnt_idx] = 1'b1;
            if (host.resp_ready[r_gnt_idx]) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request capture, round-robin pointer, watchdog and result/error capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr  <= '0;
         r_gnt_idx <= '0;
         r_mode    <= 1'b0;
         r_key     <= '0;
         r_data    <= '0;
         r_result  <= '0;
         r_err     <= 1'b0;
         r_wdog    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_gnt_idx <= w_gnt;
                  r_rr_ptr  <= (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + IDW'(1);
                  r_mode    <= host.req_mode[w_gnt];
                  r_key     <= host.req_key[int'(w_gnt) * AES_BLK_W +: AES_BLK_W];
                  r_data    <= host.req_data[int'(w_gnt) * AES_BLK_W +: AES_BLK_W];
               end
            end
            ST_START: r_wdog <= '0;
            ST_WAIT: begin
               if (core_ready) begin
                  r_result <= core_cipher;
                  r_err    <= 1'b0;
               end else if (w_timeout) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter with a transaction-level reference model
// and a behavioural AES core (programmable latency, FIPS-197 known answers).
module tb_aes_core_arbiter;
   import aes_ctrl_pkg::*;

   localparam int N   = 2;
   localparam int IDW = 1;
   localparam int TO  = 64;

   localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst;
   logic         core_start, core_mode, core_ready, busy;
   logic [127:0] core_key, core_in, core_cipher;

   always #5 clk = ~clk;

   aes_core_arbiter_if #(.NUM_REQ(N)) host_if();

   aes_core_arbiter #(.NUM_REQ(N), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (host_if),
      .core_start  (core_start),
      .core_mode   (core_mode),
      .core_key    (core_key),
      .core_in     (core_in),
      .core_cipher (core_cipher),
      .core_ready  (core_ready),
      .busy        (busy)
   );

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // stimulus state
   logic [N-1:0] d_valid = '0, d_mode = '0, d_rready = '0;
   logic [127:0] d_key [N];
   logic [127:0] d_data [N];
   bit           d_rst = 1'b1;
   bit           refill = 1'b0;
   bit           rand_lat = 1'b0;
   // behavioural core
   int           core_lat = 3;
   bit           core_never = 1'b0;
   int           core_rdy_cyc = -1;
   logic [127:0] core_res = '0;
   // transaction model
   bit           m_busy = 1'b0;
   int           m_idx = 0, m_ptr = 0, t_acc = -10, t_resp = -1;
   logic         m_mode;
   logic [127:0] m_key, m_in, m_exp;
   bit           m_err;
   int           grant_log [$];
   logic [127:0] rlog_data [$];
   bit           rlog_err [$];
   int           rlog_idx [$];
   int           rlog_lat [$];

   // Core function: FIPS-197 known answers, otherwise an arbitrary but fixed mapping
   function automatic logic [127:0] aes_ref(logic mode, logic [127:0] key, logic [127:0] blk);
      if (key == FK && mode == MODE_ENC && blk == FP) return FC;
      if (key == FK && mode == MODE_DEC && blk == FC) return FP;
      return blk ^ {key[63:0], key[127:64]} ^ (mode ? {4{32'ha5a55a5a}} : {4{32'h3c3cc3c3}});
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic set_req(int r, logic mode, logic [127:0] key, logic [127:0] blk);
      d_valid[r] = 1'b1;
      d_mode[r]  = mode;
      d_key[r]   = key;
      d_data[r]  = blk;
   endtask

   task automatic new_payload(int r);
      set_req(r, 1'($urandom % 2), {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom});
   endtask

   // Compare every DUT output against the transaction model for the current cycle
   task automatic monitor();
      bit           was_busy, found;
      int           g, lat;
      logic [N-1:0] exp_rdy, exp_rv;
      if (d_rst) begin
         chk("rst_ctrl", {host_if.req_ready, host_if.resp_valid, host_if.resp_err,
                          core_start, core_mode, busy}, '0);
         chk("rst_data", host_if.resp_data | core_key | core_in, '0);
         m_busy = 1'b0;
         m_ptr  = 0;
         return;
      end
      was_busy = m_busy;
      // round-robin: first valid requester at or after the pointer, only when nothing is in flight
      exp_rdy = '0;
      found   = 1'b0;
      g       = 0;
      if (!was_busy) begin
         for (int k = 0; k < N; k++) begin
            automatic int r = (m_ptr + k) % N;
            if (!found && d_valid[r]) begin
               found = 1'b1;
               g     = r;
            end
         end
      end
      if (found) exp_rdy[g] = 1'b1;
      chk("req_ready", host_if.req_ready, exp_rdy);
      if (found) begin
         m_busy = 1'b1;
         m_idx  = g;
         t_acc  = cyc;
         t_resp = -1;
         m_mode = d_mode[g];
         m_key  = d_key[g];
         m_in   = d_data[g];
         m_exp  = aes_ref(d_mode[g], d_key[g], d_data[g]);
         m_ptr  = (g + 1) % N;
         grant_log.push_back(g);
         if (refill) new_payload(g);
         else d_valid[g] = 1'b0;
      end
      chk("busy", busy, m_busy && cyc > t_acc);
      chk("core_start", core_start, m_busy && cyc == t_acc + 1);
      if (m_busy && cyc > t_acc && (t_resp < 0 || cyc < t_resp)) begin
         chk("core_mode", core_mode, m_mode);
         chk("core_key", core_key, m_key);
         chk("core_in", core_in, m_in);
      end
      // ready is honoured in the TO cycles following core_start; otherwise abort
      if (m_busy && t_resp < 0 && cyc >= t_acc + 2) begin
         if (core_ready) begin
            t_resp = cyc + 1;
            m_err  = 1'b0;
         end else if (cyc - (t_acc + 2) == TO - 1) begin
            t_resp = cyc + 1;
            m_err  = 1'b1;
            m_exp  = '0;
         end
      end
      exp_rv = '0;
      if (m_busy && t_resp >= 0 && cyc >= t_resp) exp_rv[m_idx] = 1'b1;
      chk("resp_valid", host_if.resp_valid, exp_rv);
      if (exp_rv != '0) begin
         chk("resp_data", host_if.resp_data, m_exp);
         chk("resp_err", host_if.resp_err, m_err);
         if (cyc == t_resp) begin
            rlog_data.push_back(host_if.resp_data);
            rlog_err.push_back(host_if.resp_err);
            rlog_idx.push_back(m_idx);
            rlog_lat.push_back(cyc - (t_acc + 1));
         end
         if (d_rready[m_idx]) m_busy = 1'b0;
      end
      // behavioural core reacts to the start pulse; it is never flushed by reset
      if (core_start) begin
         if (core_never) core_rdy_cyc = -1;
         else begin
            lat = rand_lat ? (($urandom % 8 == 0) ? $urandom_range(TO + 2, TO - 1)
                                                  : $urandom_range(5, 1)) : core_lat;
            core_rdy_cyc = cyc + lat;
            core_res     = aes_ref(core_mode, core_key, core_in);
         end
      end
   endtask

   // One clock: drive inputs on the falling edge, then check settled outputs
   task automatic step();
      @(negedge clk);
      rst                = d_rst;
      host_if.req_valid  = d_valid;
      host_if.req_mode   = d_mode;
      for (int r = 0; r < N; r++) begin
         host_if.req_key[128*r +: 128]  = d_key[r];
         host_if.req_data[128*r +: 128] = d_data[r];
      end
      host_if.resp_ready = d_rready;
      core_ready         = (cyc == core_rdy_cyc);
      core_cipher        = core_ready ? core_res : {$urandom, $urandom, $urandom, $urandom};
      #1;
      monitor();
      cyc++;
   endtask

   task automatic wait_idle(int budget);
      int n = 0;
      d_rready = '1;
      while ((m_busy || d_valid != '0) && n < budget) begin
         step();
         n++;
      end
      if (m_busy || d_valid != '0) begin
         compared++;
         mismatched++;
         $display("FAIL wait_idle cyc=%0d got=busy want=idle within %0d cycles", cyc, budget);
      end
   endtask

   int exp_order [6] = '{0, 1, 0, 1, 0, 1};
   int n_before;
   int guard;

   initial begin
      for (int r = 0; r < N; r++) begin
         d_key[r]  = '0;
         d_data[r] = '0;
      end
      d_rst = 1'b1;
      repeat (3) step();
      d_rst = 1'b0;
      step();

      // single encrypt on requester 0
      core_lat = 5;
      set_req(0, MODE_ENC, FK, FP);
      wait_idle(200);
      chk("t1_data", rlog_data[$], FC);
      chk("t1_err", 128'(rlog_err[$]), '0);
      chk("t1_idx", 128'(rlog_idx[$]), 128'd0);
      chk("t1_lat", 128'(rlog_lat[$]), 128'd6);

      // single decrypt on requester 1
      set_req(1, MODE_DEC, FK, FC);
      wait_idle(200);
      chk("t2_data", rlog_data[$], FP);
      chk("t2_idx", 128'(rlog_idx[$]), 128'd1);

      // both requesters held busy: strict alternation
      core_lat = 2;
      refill   = 1'b1;
      grant_log.delete();
      new_payload(0);
      new_payload(1);
      guard = 0;
      while (grant_log.size() < 6 && guard < 200) begin
         step();
         guard++;
      end
      refill  = 1'b0;
      d_valid = '0;
      wait_idle(200);
      for (int i = 0; i < 6; i++) chk("t3_order", 128'(grant_log[i]), 128'(exp_order[i]));

      // core never answers: abort, then the last allowed cycle still counts as ready
      core_never = 1'b1;
      set_req(0, MODE_ENC, FK, FP);
      wait_idle(TO + 20);
      chk("t4_err", 128'(rlog_err[$]), 128'd1);
      chk("t4_data", rlog_data[$], '0);
      chk("t4_lat", 128'(rlog_lat[$]), 128'(TO + 1));
      core_never = 1'b0;
      core_lat   = TO;
      set_req(1, MODE_ENC, FK, FP);
      wait_idle(TO + 20);
      chk("t4b_err", 128'(rlog_err[$]), '0);
      chk("t4b_data", rlog_data[$], FC);

      // response back-pressure with another request pending
      core_lat = 3;
      d_rready = '0;
      set_req(1, MODE_DEC, FK, FC);
      guard = 0;
      while (!(m_busy && t_resp >= 0 && cyc >= t_resp) && guard < 50) begin
         step();
         guard++;
      end
      new_payload(0);
      repeat (10) step();
      wait_idle(200);
      chk("t5_data", rlog_data[rlog_data.size() - 2], FP);

      // reset while waiting on the core; its late ready must be discarded
      core_lat = 20;
      set_req(0, MODE_ENC, FK, FP);
      guard = 0;
      while (!(m_busy && cyc == t_acc + 5) && guard < 50) begin
         step();
         guard++;
      end
      n_before = rlog_data.size();
      d_rst = 1'b1;
      step();
      d_rst = 1'b0;
      repeat (25) step();
      chk("t6_no_resp", 128'(rlog_data.size()), 128'(n_before));
      core_lat = 4;
      set_req(1, MODE_DEC, FK, FC);
      wait_idle(200);
      chk("t6_data", rlog_data[$], FP);

      // randomized traffic, back-pressure, drops, long latencies and resets
      rand_lat = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         for (int r = 0; r < N; r++) begin
            if (!d_valid[r] && ($urandom % 4 == 0)) new_payload(r);
            else if (d_valid[r] && ($urandom % 32 == 0)) d_valid[r] = 1'b0;
         end
         d_rready = N'($urandom);
         d_rst    = ($urandom % 500 == 0);
         step();
      end
      d_rst   = 1'b0;
      d_valid = '0;
      wait_idle(TO + 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
